free_list: RTL and testbench

FREE_LIST -- requirements
Module: free_list

---
 rtl/rv32i_types.sv | 9 +
 rtl/lane_popcount.sv | 21 ++
 rtl/free_list.sv | 72 +++++++
 tb/tb_free_list.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// rv32i_types: shared rename-stage parameters and physical-register types
package rv32i_types;
    localparam int PREGS = 64;
    localparam int SS = 2;
    localparam int FL_DEPTH = PREGS - 32;
    localparam int FL_PW = $clog2(FL_DEPTH) + 1;
    typedef logic [5:0] preg_t;
    typedef logic [FL_PW-1:0] fl_ptr_t;
endpackage

// File: rtl/lane_popcount.sv
// lane_popcount: total set lanes plus, per lane, the count of set lanes below it
module lane_popcount #(
    parameter int SS = 2,
    parameter int CW = $clog2(SS) + 1
) (
    input  logic [SS-1:0]         vec,
    output logic [CW-1:0]         total,
    output logic [SS-1:0][CW-1:0] prefix
);
    logic [CW-1:0] acc;
    // Running sum across lanes; each lane records the sum before adding itself
    always_comb begin
        acc = '0;
        prefix = '0;
        for (int i = 0; i < SS; i++) begin
            prefix[i] = acc;
            acc = acc + CW'(vec[i]);
        end
        total = acc;
    end
endmodule

// File: rtl/free_list.sv
// free_list: circular queue of free physical registers for superscalar rename
module free_list
    import rv32i_types::preg_t;
#(
    parameter int SS = rv32i_types::SS,
    parameter int PREGS = rv32i_types::PREGS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SS-1:0]                 alloc_req,
    output preg_t [SS-1:0]                alloc_preg,
    output logic                          alloc_ok,
    input  logic [SS-1:0]                 release_valid,
    input  preg_t [SS-1:0]                release_preg,
    input  logic                          flush,
    output logic [$clog2(PREGS-32):0]     free_count,
    output logic                          empty,
    output logic                          full
);
    localparam int DEPTH = PREGS - 32;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(SS) + 1;

    preg_t                 mem [DEPTH];
    logic [PW-1:0]         head, tail, head_next, tail_next, count_next, a_take;
    logic [CW-1:0]         a_cnt, r_cnt;
    logic [SS-1:0][CW-1:0] a_pre, r_pre;

    lane_popcount #(.SS(SS), .CW(CW)) u_alloc_cnt (.vec(alloc_req), .total(a_cnt), .prefix(a_pre));
    lane_popcount #(.SS(SS), .CW(CW)) u_rel_cnt (.vec(release_valid), .total(r_cnt), .prefix(r_pre));

    // Offer the next SS entries from head regardless of the request
    always_comb begin
        for (int i = 0; i < SS; i++) alloc_preg[i] = mem[head[AW-1:0] + AW'(i)];
    end

    assign alloc_ok   = free_count >= PW'(a_cnt);
    assign a_take     = (alloc_ok && !flush) ? PW'(a_cnt) : '0;
    assign tail_next  = tail + PW'(r_cnt);
    assign head_next  = flush ? {~tail_next[PW-1], tail_next[AW-1:0]} : head + a_take;
    assign count_next = flush ? PW'(DEPTH) : free_count + PW'(r_cnt) - a_take;
    assign empty      = head == tail;
    assign full       = head == {~tail[PW-1], tail[AW-1:0]};

    // Pointer, count and array update; released lanes are packed densely at tail
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= {1'b1, {AW{1'b0}}};
            free_count <= PW'(DEPTH);
            for (int k = 0; k < DEPTH; k++) mem[k] <= preg_t'(32 + k);
        end else begin
            head <= head_next;
            tail <= tail_next;
            free_count <= count_next;
            for (int i = 0; i < SS; i++)
                if (release_valid[i]) mem[tail[AW-1:0] + AW'(r_pre[i])] <= release_preg[i];
        end
    end

    // Flag overflowing releases, architectural-register releases and gapped requests
    always_ff @(posedge clk) begin
        if (rst) begin
            assert ({1'b0, free_count} + (PW+1)'(r_cnt) <= (PW+1)'(DEPTH) + {1'b0, a_take});
            for (int i = 0; i < SS; i++) begin
                assert (!release_valid[i] || release_preg[i] >= preg_t'(32));
                assert (!alloc_req[i] || a_pre[i] == CW'(i));
            end
        end
    end
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed and scoreboarded checks of the rename free list
module tb_free_list;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, alloc_ok, flush, empty, full;
    logic [1:0]      alloc_req, release_valid;
    logic [1:0][5:0] alloc_preg, release_preg;
    logic [5:0]      free_count;
    int n_cmp = 0;
    int n_bad = 0;
    int q[$];
    int outs[$];

    free_list dut (
        .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_preg(alloc_preg),
        .alloc_ok(alloc_ok), .release_valid(release_valid), .release_preg(release_preg),
        .flush(flush), .free_count(free_count), .empty(empty), .full(full)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] a, input logic [1:0] r, input int p0, input int p1, input logic f);
        alloc_req = a;
        release_valid = r;
        release_preg[0] = 6'(p0);
        release_preg[1] = 6'(p1);
        flush = f;
        #1;
    endtask

    task automatic model_reset;
        q.delete();
        outs.delete();
        for (int k = 32; k < 64; k++) q.push_back(k);
    endtask

    initial begin
        rst = 1'b0;
        drive(2'b11, 2'b00, 0, 0, 1'b0);
        step;
        check("rst_count", free_count, 32);
        check("rst_full", full, 1);
        check("rst_empty", empty, 0);
        check("rst_preg0", alloc_preg[0], 32);
        check("rst_preg1", alloc_preg[1], 33);
        check("rst_ok", alloc_ok, 1);
        rst = 1'b1;
        // first pair allocated, next pair offered
        step;
        check("a1_preg0", alloc_preg[0], 34);
        check("a1_preg1", alloc_preg[1], 35);
        check("a1_count", free_count, 30);
        repeat (15) step;
        check("drain_empty", empty, 1);
        check("drain_ok", alloc_ok, 0);
        check("drain_count", free_count, 0);
        drive(2'b00, 2'b00, 0, 0, 1'b0);
        check("zero_req_ok", alloc_ok, 1);
        drive(2'b01, 2'b00, 0, 0, 1'b0);
        check("one_req_ok", alloc_ok, 0);
        drive(2'b11, 2'b00, 0, 0, 1'b0);
        step;
        check("hold_preg0", alloc_preg[0], 32);
        check("hold_count", free_count, 0);
        check("hold_empty", empty, 1);
        // lane 1 only: compacted into the tail slot
        drive(2'b00, 2'b10, 5, 40, 1'b0);
        step;
        check("comp_count", free_count, 1);
        check("comp_empty", empty, 0);
        drive(2'b01, 2'b00, 0, 0, 1'b0);
        check("comp_ok", alloc_ok, 1);
        check("comp_preg0", alloc_preg[0], 40);
        step;
        check("comp_after", free_count, 0);
        drive(2'b00, 2'b01, 45, 0, 1'b0);
        step;
        check("one_count", free_count, 1);
        drive(2'b11, 2'b11, 50, 51, 1'b0);
        check("same_ok", alloc_ok, 0);
        step;
        check("same_count", free_count, 3);
        check("same_preg0", alloc_preg[0], 45);
        check("same_preg1", alloc_preg[1], 50);
        drive(2'b00, 2'b11, 52, 53, 1'b0); step;
        drive(2'b00, 2'b11, 54, 55, 1'b0); step;
        drive(2'b00, 2'b11, 56, 57, 1'b0); step;
        drive(2'b00, 2'b01, 58, 0, 1'b0); step;
        check("ten_count", free_count, 10);
        drive(2'b11, 2'b11, 59, 60, 1'b0);
        check("ten_ok", alloc_ok, 1);
        step;
        check("ten_same", free_count, 10);
        check("ten_preg0", alloc_preg[0], 51);
        check("ten_preg1", alloc_preg[1], 52);
        // asynchronous reset with everything active
        drive(2'b11, 2'b11, 33, 34, 1'b1);
        rst = 1'b0;
        #1;
        check("mid_rst_count", free_count, 32);
        check("mid_rst_full", full, 1);
        check("mid_rst_preg0", alloc_preg[0], 32);
        check("mid_rst_preg1", alloc_preg[1], 33);
        step;
        check("mid_rst_hold", free_count, 32);
        rst = 1'b1;
        drive(2'b11, 2'b00, 0, 0, 1'b0);
        repeat (10) step;
        check("a20_count", free_count, 12);
        check("a20_preg0", alloc_preg[0], 52);
        drive(2'b11, 2'b01, 32, 0, 1'b1);
        step;
        check("flush_count", free_count, 32);
        check("flush_full", full, 1);
        check("flush_preg0", alloc_preg[0], 33);
        check("flush_preg1", alloc_preg[1], 34);
        // scoreboarded random traffic with a reset in the middle
        drive(2'b00, 2'b00, 0, 0, 1'b0);
        rst = 1'b0;
        step;
        rst = 1'b1;
        model_reset();
        for (int c = 0; c < 1200; c++) begin
            int na;
            int p[2];
            logic [1:0] req, rv;
            bit ok;
            if (c == 600) begin
                drive(2'b11, 2'b00, 0, 0, 1'b0);
                rst = 1'b0;
                #1;
                check("rnd_rst_count", free_count, 32);
                check("rnd_rst_full", full, 1);
                check("rnd_rst_preg0", alloc_preg[0], 32);
                step;
                rst = 1'b1;
                model_reset();
            end
            na = $urandom_range(0, 2);
            req = (na == 0) ? 2'b00 : (na == 1) ? 2'b01 : 2'b11;
            rv = 2'b00;
            for (int l = 0; l < 2; l++) begin
                p[l] = $urandom_range(0, 63);
                if (outs.size() > 0 && $urandom_range(0, 1) == 1) begin
                    int idx;
                    idx = int'($urandom_range(0, outs.size() - 1));
                    p[l] = outs[idx];
                    outs.delete(idx);
                    rv[l] = 1'b1;
                end
            end
            drive(req, rv, p[0], p[1], 1'b0);
            ok = q.size() >= na;
            check("rnd_ok", alloc_ok, ok);
            check("rnd_count", free_count, q.size());
            if (q.size() >= 1) check("rnd_preg0", alloc_preg[0], q[0]);
            if (q.size() >= 2) check("rnd_preg1", alloc_preg[1], q[1]);
            if (ok) begin
                for (int k = 0; k < na; k++) begin
                    int found;
                    found = 0;
                    foreach (outs[j]) if (outs[j] == int'(alloc_preg[k])) found = 1;
                    check("rnd_dup", found, 0);
                    outs.push_back(q.pop_front());
                end
            end
            for (int l = 0; l < 2; l++) if (rv[l]) q.push_back(p[l]);
            step;
        end
        check("rnd_final", free_count, q.size());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
